// File: rtl/ula_arbiter.sv
// Shares one combinational ULA between two requesters (round-robin or fixed priority) and screens illegal ops.
// Latency: gnt one cycle after the accepting edge, done one cycle after gnt; one operation every 3 cycles.
// Backpressure: req is level-held until done; a losing requester waits in IDLE with its req still high.
module ula_arbiter #(
    parameter bit         RR_ENABLE = 1'b1,
    parameter logic [7:0] ERR_VALUE = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] op0_a,
    input  logic [3:0] op0_b,
    input  logic [3:0] op0_code,
    input  logic       req1,
    input  logic [3:0] op1_a,
    input  logic [3:0] op1_b,
    input  logic [3:0] op1_code,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] result_out,
    output logic       op_err,
    output logic       busy,
    output logic [3:0] ula_operando1,
    output logic [3:0] ula_operando2,
    output logic [3:0] ula_opcode,
    input  logic [7:0] ula_result
);
    localparam logic [3:0] ULA_ADD  = 4'h0;
    localparam logic [3:0] ULA_SUB  = 4'h1;
    localparam logic [3:0] ULA_MULT = 4'h2;
    localparam logic [3:0] ULA_DIV  = 4'h3;
    localparam logic [3:0] ULA_AND  = 4'h4;
    localparam logic [3:0] ULA_OR   = 4'h5;
    localparam logic [3:0] ULA_XOR  = 4'h6;
    localparam logic [3:0] ULA_NOT  = 4'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   pick1;
    logic   winner;
    logic   prio1;      // 1 = port 1 wins the next tie
    logic   illegal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        pick1     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                    if (req0 && req1) pick1 = RR_ENABLE ? prio1 : 1'b0;
                    else              pick1 = req1;
                end
            end
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decide legality from the latched opcode/operand so a ULA X never reaches result_out.
    always_comb begin
        illegal = 1'b0;
        case (ula_opcode)
            ULA_ADD, ULA_SUB, ULA_MULT, ULA_AND,
            ULA_OR, ULA_XOR, ULA_NOT: illegal = 1'b0;
            ULA_DIV:                  illegal = (ula_operando2 == 4'h0);
            default:                  illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            result_out    <= 8'h00;
            op_err        <= 1'b0;
            ula_operando1 <= 4'h0;
            ula_operando2 <= 4'h0;
            ula_opcode    <= 4'h0;
            winner        <= 1'b0;
            prio1         <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (accept) begin
                ula_operando1 <= pick1 ? op1_a    : op0_a;
                ula_operando2 <= pick1 ? op1_b    : op0_b;
                ula_opcode    <= pick1 ? op1_code : op0_code;
                winner        <= pick1;
                gnt0          <= !pick1;
                gnt1          <= pick1;
            end
            if (state == EXEC) begin
                result_out <= illegal ? ERR_VALUE : ula_result;
                op_err     <= illegal;
                done0      <= !winner;
                done1      <= winner;
            end
            if (state == DONE) prio1 <= RR_ENABLE ? !winner : 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: round-robin instance plus a fixed-priority instance, each with a ULA model.
module tb_ula_arbiter;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MULT = 4'h2, DIV = 4'h3;
    localparam logic [3:0] AND_ = 4'h4, XOR_ = 4'h6, NOT_ = 4'h7;

    logic       clock, reset;
    logic       req0, req1;
    logic [3:0] op0_a, op0_b, op0_code, op1_a, op1_b, op1_code;
    logic       gnt0, gnt1, done0, done1, op_err, busy;
    logic [7:0] result_out, ula_result;
    logic [3:0] ula_operando1, ula_operando2, ula_opcode;
    logic       f_gnt0, f_gnt1, f_done0, f_done1, f_op_err, f_busy;
    logic [7:0] f_result_out, f_ula_result;
    logic [3:0] f_ula_operando1, f_ula_operando2, f_ula_opcode;

    int checks = 0;
    int passes = 0;

    ula_arbiter #(.RR_ENABLE(1'b1), .ERR_VALUE(8'h00)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .op0_a(op0_a), .op0_b(op0_b), .op0_code(op0_code),
        .req1(req1), .op1_a(op1_a), .op1_b(op1_b), .op1_code(op1_code),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result_out(result_out), .op_err(op_err), .busy(busy),
        .ula_operando1(ula_operando1), .ula_operando2(ula_operando2),
        .ula_opcode(ula_opcode), .ula_result(ula_result)
    );

    ula_arbiter #(.RR_ENABLE(1'b0), .ERR_VALUE(8'h00)) dut_fp (
        .clock(clock), .reset(reset),
        .req0(req0), .op0_a(op0_a), .op0_b(op0_b), .op0_code(op0_code),
        .req1(req1), .op1_a(op1_a), .op1_b(op1_b), .op1_code(op1_code),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
        .result_out(f_result_out), .op_err(f_op_err), .busy(f_busy),
        .ula_operando1(f_ula_operando1), .ula_operando2(f_ula_operando2),
        .ula_opcode(f_ula_opcode), .ula_result(f_ula_result)
    );

    function automatic logic [7:0] ula(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [7:0] ea, eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (c)
            4'h0:    return ea + eb;
            4'h1:    return ea - eb;
            4'h2:    return ea * eb;
            4'h3:    return (b == 4'h0) ? 8'hxx : ea / eb;
            4'h4:    return ea & eb;
            4'h5:    return ea | eb;
            4'h6:    return ea ^ eb;
            4'h7:    return ~ea;
            default: return 8'hxx;
        endcase
    endfunction

    assign ula_result   = ula(ula_operando1, ula_operando2, ula_opcode);
    assign f_ula_result = ula(f_ula_operando1, f_ula_operando2, f_ula_opcode);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set0(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        op0_a = a; op0_b = b; op0_code = c; req0 = 1'b1;
    endtask

    task automatic set1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        op1_a = a; op1_b = b; op1_code = c; req1 = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, busy, op_err} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, busy, op_err});
        else passes++;
        checks++;
        if ({result_out, ula_operando1, ula_operando2, ula_opcode} !== 20'h0)
            $display("FAIL reset_data: got %h want 00000", {result_out, ula_operando1, ula_operando2, ula_opcode});
        else passes++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_add();
        set0(4'h9, 4'h8, ADD);
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b10001)
            $display("FAIL add_gnt: got %b want 10001", {gnt0, gnt1, done0, done1, busy});
        else passes++;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b00101)
            $display("FAIL add_done: got %b want 00101", {gnt0, gnt1, done0, done1, busy});
        else passes++;
        checks++;
        if ({result_out, op_err} !== {8'h11, 1'b0})
            $display("FAIL add_result: got %h/%b want 11/0", result_out, op_err);
        else passes++;
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, busy, result_out} !== {5'b00000, 8'h11})
            $display("FAIL add_idle: got %b/%h want 00000/11", {gnt0, gnt1, done0, done1, busy}, result_out);
        else passes++;
    endtask

    task automatic test_port1_ops();
        logic [3:0]  code [3] = '{SUB, MULT, NOT_};
        logic [3:0]  a    [3] = '{4'h3, 4'hF, 4'h5};
        logic [3:0]  b    [3] = '{4'h5, 4'hF, 4'h0};
        logic [7:0]  exp  [3] = '{8'hFE, 8'hE1, 8'hFA};
        for (int i = 0; i < 3; i++) begin
            set1(a[i], b[i], code[i]);
            tick();
            checks++;
            if ({gnt0, gnt1, done0, done1} !== 4'b0100)
                $display("FAIL p1_gnt[%0d]: got %b want 0100", i, {gnt0, gnt1, done0, done1});
            else passes++;
            tick();
            checks++;
            if ({done0, done1, result_out, op_err} !== {2'b01, exp[i], 1'b0})
                $display("FAIL p1_done[%0d]: got %b/%h/%b want 01/%h/0", i, {done0, done1}, result_out, op_err, exp[i]);
            else passes++;
            req1 = 1'b0;
            tick();
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set0(4'h1, 4'h2, ADD);
        set1(4'h5, 4'hF, XOR_);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01) || {f_gnt0, f_gnt1} !== 2'b10)
                $display("FAIL rr_gnt[%0d]: got rr=%b fp=%b want rr=%b fp=10", k,
                         {gnt0, gnt1}, {f_gnt0, f_gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            else passes++;
            tick();
            checks++;
            if ((k % 2 == 0) ? ({done0, done1, result_out} !== {2'b10, 8'h03})
                             : ({done0, done1, result_out} !== {2'b01, 8'h0A}))
                $display("FAIL rr_done[%0d]: got %b/%h want %s", k, {done0, done1}, result_out,
                         (k % 2 == 0) ? "10/03" : "01/0a");
            else passes++;
            checks++;
            if ({f_done0, f_done1, f_result_out, f_op_err} !== {2'b10, 8'h03, 1'b0})
                $display("FAIL fp_done[%0d]: got %b/%h/%b want 10/03/0", k, {f_done0, f_done1}, f_result_out, f_op_err);
            else passes++;
            tick();
            checks++;
            if ({busy, f_busy} !== 2'b00)
                $display("FAIL rr_idle[%0d]: got busy %b want 00", k, {busy, f_busy});
            else passes++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_div_and_unknown();
        logic [3:0] b    [3] = '{4'h0, 4'h2, 4'h3};
        logic [3:0] code [3] = '{DIV, DIV, 4'hC};
        logic [8:0] exp  [3] = '{{8'h00, 1'b1}, {8'h03, 1'b0}, {8'h00, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            set0(4'h7, b[i], code[i]);
            tick();
            tick();
            checks++;
            if ({result_out, op_err} !== exp[i] || done0 !== 1'b1)
                $display("FAIL err_screen[%0d]: got %h/%b done0=%b want %h/%b done0=1", i,
                         result_out, op_err, done0, exp[i][8:1], exp[i][0]);
            else passes++;
            checks++;
            if ($isunknown({gnt0, gnt1, done0, done1, busy, op_err, result_out}))
                $display("FAIL no_x[%0d]: got X on outputs, want none", i);
            else passes++;
            req0 = 1'b0;
            tick();
        end
    endtask

    task automatic test_operand_change();
        set0(4'hA, 4'h6, AND_);
        tick();
        op0_a = 4'hF; op0_b = 4'hF; op0_code = 4'h5;
        tick();
        checks++;
        if ({done0, result_out, op_err} !== {1'b1, 8'h02, 1'b0})
            $display("FAIL latch_ops: got %b/%h/%b want 1/02/0", done0, result_out, op_err);
        else passes++;
        req0 = 1'b0;
        tick();
        tick();
        checks++;
        if ({ula_operando1, ula_operando2, ula_opcode} !== {4'hA, 4'h6, AND_})
            $display("FAIL ula_hold: got %h want a6%h", {ula_operando1, ula_operando2, ula_opcode}, AND_);
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        set0(4'h1, 4'h1, ADD);
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, busy, op_err, result_out, ula_operando1, ula_operando2, ula_opcode} !== 26'h0)
            $display("FAIL async_reset: got %h want 0", {gnt0, gnt1, done0, done1, busy, op_err, result_out,
                                                         ula_operando1, ula_operando2, ula_opcode});
        else passes++;
        req0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({done0, done1, busy} !== 3'b000)
            $display("FAIL no_done_after_reset: got %b want 000", {done0, done1, busy});
        else passes++;
        set0(4'h2, 4'h3, ADD);
        set1(4'h4, 4'h4, ADD);
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10)
            $display("FAIL reset_prio: got %b want 10", {gnt0, gnt1});
        else passes++;
        tick();
        checks++;
        if ({done0, done1, result_out, op_err} !== {2'b10, 8'h05, 1'b0})
            $display("FAIL reset_reop: got %b/%h/%b want 10/05/0", {done0, done1}, result_out, op_err);
        else passes++;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0_a = 4'h0; op0_b = 4'h0; op0_code = 4'h0;
        op1_a = 4'h0; op1_b = 4'h0; op1_code = 4'h0;
        test_reset();
        test_add();
        test_port1_ops();
        test_round_robin();
        test_div_and_unknown();
        test_operand_change();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
